// File: rtl/engine_seq_pkg.sv
// Shared state encodings and default parameters for the engine frame sequencer.
package engine_seq_pkg;

    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_N_IO_CHANNELS  = 2;
    localparam int DEF_N_PIPELINES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 4096;
    localparam int DEF_CTR_WIDTH      = 32;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GAIN_REQ,
        S_GAIN_WAIT,
        S_TICK,
        S_SETTLE,
        S_PROC_WAIT,
        S_MIX_REQ,
        S_MIX_WAIT,
        S_EMIT
    } seq_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic is_wait_state(input seq_state_t s);
        return (s == S_GAIN_WAIT) || (s == S_PROC_WAIT) || (s == S_MIX_WAIT);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Wait-state watchdog: counts cycles spent in a wait state, restarts on every state change.
module seq_watchdog #(
    parameter int timeout_cycles = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic restart,
    output logic expired
);

    localparam int CW = $clog2(timeout_cycles + 1);

    logic [CW-1:0] count_q, count_d;

    // count_q is the number of cycles already completed in the current wait state
    assign expired = active && (count_q == CW'(timeout_cycles - 1));

    always_comb begin
        count_d = count_q;
        if (restart || !active) begin
            count_d = '0;
        end else if (!expired) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/engine_frame_sequencer.sv
// Walks each channel of an input frame through gain, pipeline tick and mixer, then emits the frame.
module engine_frame_sequencer
    import engine_seq_pkg::*;
#(
    parameter int data_width     = DEF_DATA_WIDTH,
    parameter int n_io_channels  = DEF_N_IO_CHANNELS,
    parameter int n_pipelines    = DEF_N_PIPELINES,
    parameter int timeout_cycles = DEF_TIMEOUT_CYCLES,
    parameter int ctr_width      = DEF_CTR_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [n_io_channels*data_width-1:0]   in_frame,
    input  logic                                  frame_valid,
    output logic                                  ready,
    output logic                                  gain_req,
    output logic [data_width-1:0]                 gain_sample,
    input  logic                                  gain_done,
    input  logic [data_width-1:0]                 gain_result,
    output logic                                  pipe_tick,
    output logic [data_width-1:0]                 pipe_sample,
    output logic [idx_width(n_io_channels)-1:0]   pipe_channel,
    input  logic [n_pipelines-1:0]                pipe_enable,
    input  logic [n_pipelines-1:0]                pipe_ready,
    output logic                                  mix_req,
    input  logic                                  mix_done,
    input  logic [data_width-1:0]                 mix_result,
    output logic [n_io_channels*data_width-1:0]   out_frame,
    output logic                                  out_valid,
    output logic                                  timeout_flag,
    output logic [ctr_width-1:0]                  overrun_count,
    output logic [ctr_width-1:0]                  frame_count,
    input  logic                                  clear_status
);

    localparam int CHW = idx_width(n_io_channels);
    localparam int FW  = n_io_channels * data_width;
    localparam logic [CHW-1:0] LAST_CH = CHW'(n_io_channels - 1);

    seq_state_t            state_q, state_d;
    logic [CHW-1:0]        ch_q, ch_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic                  ready_q, ready_d;
    logic                  gain_req_q, gain_req_d;
    logic [data_width-1:0] gain_sample_q, gain_sample_d;
    logic                  pipe_tick_q, pipe_tick_d;
    logic [data_width-1:0] pipe_sample_q, pipe_sample_d;
    logic                  mix_req_q, mix_req_d;
    logic                  out_valid_q, out_valid_d;
    logic                  timeout_q, timeout_d;
    logic [ctr_width-1:0]  overrun_q, overrun_d;
    logic [ctr_width-1:0]  frame_cnt_q, frame_cnt_d;

    logic                  slot_we;
    logic [data_width-1:0] slot_wdata;
    logic                  chan_done;
    logic                  timeout_evt;
    logic                  overrun_evt;
    logic                  pipes_ok;
    logic                  wd_active, wd_restart, wd_expired;
    logic [data_width-1:0] frame_slot [n_io_channels];

    for (genvar g = 0; g < n_io_channels; g++) begin : g_slot
        logic [data_width-1:0] slot_q;

        assign frame_slot[g] = frame_q[g*data_width +: data_width];
        assign out_frame[g*data_width +: data_width] = slot_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                slot_q <= '0;
            end else if (slot_we && (ch_q == CHW'(g))) begin
                slot_q <= slot_wdata;
            end
        end
    end

    assign wd_active  = is_wait_state(state_q);
    assign wd_restart = (state_d != state_q);

    seq_watchdog #(
        .timeout_cycles(timeout_cycles)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .active (wd_active),
        .restart(wd_restart),
        .expired(wd_expired)
    );

    assign pipes_ok    = &(pipe_ready | ~pipe_enable);
    assign overrun_evt = frame_valid && (state_q != S_IDLE);

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        frame_d       = frame_q;
        gain_sample_d = gain_sample_q;
        pipe_sample_d = pipe_sample_q;
        frame_cnt_d   = frame_cnt_q;
        timeout_d     = timeout_q;
        overrun_d     = overrun_q;
        gain_req_d    = 1'b0;
        pipe_tick_d   = 1'b0;
        mix_req_d     = 1'b0;
        out_valid_d   = 1'b0;
        slot_we       = 1'b0;
        slot_wdata    = '0;
        chan_done     = 1'b0;
        timeout_evt   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_valid) begin
                    frame_d       = in_frame;
                    ch_d          = '0;
                    gain_sample_d = in_frame[data_width-1:0];
                    gain_req_d    = 1'b1;
                    state_d       = S_GAIN_REQ;
                end
            end
            S_GAIN_REQ: state_d = S_GAIN_WAIT;
            S_GAIN_WAIT: begin
                if (gain_done) begin
                    pipe_sample_d = gain_result;
                    pipe_tick_d   = 1'b1;
                    state_d       = S_TICK;
                end else if (wd_expired) begin
                    timeout_evt = 1'b1;
                end
            end
            S_TICK:   state_d = S_SETTLE;
            S_SETTLE: state_d = S_PROC_WAIT;
            S_PROC_WAIT: begin
                if (pipes_ok) begin
                    mix_req_d = 1'b1;
                    state_d   = S_MIX_REQ;
                end else if (wd_expired) begin
                    timeout_evt = 1'b1;
                end
            end
            S_MIX_REQ: state_d = S_MIX_WAIT;
            S_MIX_WAIT: begin
                if (mix_done) begin
                    slot_we    = 1'b1;
                    slot_wdata = mix_result;
                    chan_done  = 1'b1;
                end else if (wd_expired) begin
                    timeout_evt = 1'b1;
                end
            end
            S_EMIT: begin
                out_valid_d = 1'b1;
                frame_cnt_d = frame_cnt_q + ctr_width'(1);
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A timeout mutes the slot and then behaves exactly like a completed channel
        if (timeout_evt) begin
            slot_we    = 1'b1;
            slot_wdata = '0;
            chan_done  = 1'b1;
        end

        if (chan_done) begin
            if (ch_q == LAST_CH) begin
                state_d = S_EMIT;
            end else begin
                ch_d          = ch_q + CHW'(1);
                gain_sample_d = frame_slot[ch_d];
                gain_req_d    = 1'b1;
                state_d       = S_GAIN_REQ;
            end
        end

        // ready stays low for the out_valid cycle and rises one cycle later
        ready_d = (state_d == S_IDLE) && (state_q != S_EMIT);

        if (clear_status) begin
            timeout_d = 1'b0;
            overrun_d = '0;
        end else begin
            if (timeout_evt) begin
                timeout_d = 1'b1;
            end
            if (overrun_evt && (overrun_q != '1)) begin
                overrun_d = overrun_q + ctr_width'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            ch_q          <= '0;
            frame_q       <= '0;
            ready_q       <= 1'b1;
            gain_req_q    <= 1'b0;
            gain_sample_q <= '0;
            pipe_tick_q   <= 1'b0;
            pipe_sample_q <= '0;
            mix_req_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            timeout_q     <= 1'b0;
            overrun_q     <= '0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            frame_q       <= frame_d;
            ready_q       <= ready_d;
            gain_req_q    <= gain_req_d;
            gain_sample_q <= gain_sample_d;
            pipe_tick_q   <= pipe_tick_d;
            pipe_sample_q <= pipe_sample_d;
            mix_req_q     <= mix_req_d;
            out_valid_q   <= out_valid_d;
            timeout_q     <= timeout_d;
            overrun_q     <= overrun_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign ready         = ready_q;
    assign gain_req      = gain_req_q;
    assign gain_sample   = gain_sample_q;
    assign pipe_tick     = pipe_tick_q;
    assign pipe_sample   = pipe_sample_q;
    assign pipe_channel  = ch_q;
    assign mix_req       = mix_req_q;
    assign out_valid     = out_valid_q;
    assign timeout_flag  = timeout_q;
    assign overrun_count = overrun_q;
    assign frame_count   = frame_cnt_q;

endmodule

// File: tb/tb_engine_frame_sequencer.sv
// Scoreboard bench for engine_frame_sequencer with behavioural gain/pipeline/mixer responders.
module tb_engine_frame_sequencer;

    localparam int DW  = 16;
    localparam int NCH = 2;
    localparam int NP  = 2;
    localparam int TO  = 8;
    localparam int CW  = 3;
    localparam int FW  = NCH * DW;

    logic          clk, reset;
    logic [FW-1:0] in_frame;
    logic          frame_valid, ready;
    logic          gain_req, gain_done;
    logic [DW-1:0] gain_sample, gain_result;
    logic          pipe_tick;
    logic [DW-1:0] pipe_sample;
    logic [0:0]    pipe_channel;
    logic [NP-1:0] pipe_enable, pipe_ready;
    logic          mix_req, mix_done;
    logic [DW-1:0] mix_result;
    logic [FW-1:0] out_frame;
    logic          out_valid, timeout_flag, clear_status;
    logic [CW-1:0] overrun_count, frame_count;

    engine_frame_sequencer #(
        .data_width    (DW),
        .n_io_channels (NCH),
        .n_pipelines   (NP),
        .timeout_cycles(TO),
        .ctr_width     (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_frame     (in_frame),
        .frame_valid  (frame_valid),
        .ready        (ready),
        .gain_req     (gain_req),
        .gain_sample  (gain_sample),
        .gain_done    (gain_done),
        .gain_result  (gain_result),
        .pipe_tick    (pipe_tick),
        .pipe_sample  (pipe_sample),
        .pipe_channel (pipe_channel),
        .pipe_enable  (pipe_enable),
        .pipe_ready   (pipe_ready),
        .mix_req      (mix_req),
        .mix_done     (mix_done),
        .mix_result   (mix_result),
        .out_frame    (out_frame),
        .out_valid    (out_valid),
        .timeout_flag (timeout_flag),
        .overrun_count(overrun_count),
        .frame_count  (frame_count),
        .clear_status (clear_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic [FW-1:0] frame;
        logic [CW-1:0] fcnt;
        logic          tflag;
    } exp_t;
    exp_t exp_q[$];

    // Per-channel plan: 0 normal, 1 gain stuck, 2 one pipeline stuck, 3 mixer stuck
    int            plan [NCH];
    int            stuck_pipe;
    logic [NP-1:0] dead_mask;
    int            gain_lat, pipe_lat, mix_lat;
    bit            ident;
    logic [CW-1:0] exp_fcnt;
    logic          exp_tflag;
    logic [CW-1:0] exp_ovr;

    function automatic logic [DW-1:0] gainf(input logic [DW-1:0] x);
        return ident ? x : DW'(x * 3 + 5);
    endfunction

    function automatic logic [DW-1:0] mixf(input logic [DW-1:0] x, input int ch);
        return ident ? x : (x ^ ((ch != 0) ? 16'hA5A5 : 16'h0F0F));
    endfunction

    function automatic int pick(input int fixed);
        return (fixed != 0) ? fixed : int'($urandom_range(1, 4));
    endfunction

    // Gain stage responder
    initial begin
        int  cnt;
        bit  hold;
        cnt = 0;
        hold = 0;
        gain_done = 1'b0;
        gain_result = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                gain_done = 1'b0;
                cnt = 0;
                hold = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    gain_done = (cnt == 0);
                    if (cnt == 0) begin
                        gain_result = gainf(gain_sample);
                        hold = (gain_lat == 0) && ($urandom_range(0, 1) == 1);
                    end
                end else if (hold) begin
                    hold = 0;
                end else begin
                    gain_done = 1'b0;
                end
                if (gain_req && plan[pipe_channel] != 1) cnt = pick(gain_lat);
            end
        end
    end

    // Mixer responder
    initial begin
        int  cnt;
        bit  hold;
        cnt = 0;
        hold = 0;
        mix_done = 1'b0;
        mix_result = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                mix_done = 1'b0;
                cnt = 0;
                hold = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    mix_done = (cnt == 0);
                    if (cnt == 0) begin
                        mix_result = mixf(pipe_sample, int'(pipe_channel));
                        hold = (mix_lat == 0) && ($urandom_range(0, 1) == 1);
                    end
                end else if (hold) begin
                    hold = 0;
                end else begin
                    mix_done = 1'b0;
                end
                if (mix_req && plan[pipe_channel] != 3) cnt = pick(mix_lat);
            end
        end
    end

    // Pipelines: drop ready on tick, raise it again after a latency (or never when stuck)
    initial begin
        int            pcnt [NP];
        logic [NP-1:0] rdy;
        rdy = '1;
        for (int i = 0; i < NP; i++) pcnt[i] = 0;
        pipe_ready = '1;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                rdy = '1;
                for (int i = 0; i < NP; i++) pcnt[i] = 0;
            end else begin
                for (int i = 0; i < NP; i++) begin
                    if (pcnt[i] > 0) begin
                        pcnt[i]--;
                        if (pcnt[i] == 0) rdy[i] = 1'b1;
                    end
                end
                if (pipe_tick) begin
                    for (int i = 0; i < NP; i++) begin
                        rdy[i] = 1'b0;
                        pcnt[i] = (plan[pipe_channel] == 2 && stuck_pipe == i) ? -1 : pick(pipe_lat) + 1;
                    end
                end
            end
            pipe_ready = rdy & ~dead_mask;
        end
    end

    // Monitor: every out_valid pops one expected frame
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (reset === 1'b1 && out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_frame", out_frame, e.frame);
                    chk("frame_count", frame_count, e.fcnt);
                    chk("timeout_flag", timeout_flag, e.tflag);
                end
            end
        end
    end

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    task automatic send_frame(input logic [FW-1:0] data);
        int            n;
        exp_t          e;
        logic [DW-1:0] x;
        logic [NP-1:0] st, one;
        bit            to;
        n = 0;
        while (ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (ready !== 1'b1) chk("ready_wait", ready, 1'b1);
        one = 1;
        for (int c = 0; c < NCH; c++) begin
            x  = data[c*DW +: DW];
            st = dead_mask | ((plan[c] == 2) ? (one << stuck_pipe) : '0);
            to = (plan[c] == 1) || (plan[c] == 3) || ((st & pipe_enable) != '0);
            e.frame[c*DW +: DW] = to ? '0 : mixf(gainf(x), c);
            if (to) exp_tflag = 1'b1;
        end
        exp_fcnt = exp_fcnt + CW'(1);
        e.fcnt   = exp_fcnt;
        e.tflag  = exp_tflag;
        exp_q.push_back(e);
        in_frame = data;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("frame_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_fv_overrun();
        in_frame = FW'($urandom);
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        exp_ovr = sat_inc(exp_ovr);
    endtask

    task automatic set_directed();
        ident = 1;
        gain_lat = 1;
        pipe_lat = 1;
        mix_lat = 1;
        for (int c = 0; c < NCH; c++) plan[c] = 0;
        stuck_pipe = 0;
        dead_mask = '0;
        pipe_enable = '1;
    endtask

    initial begin
        int cyc;
        reset = 1'b0;
        in_frame = '0;
        frame_valid = 1'b0;
        clear_status = 1'b0;
        exp_fcnt = '0;
        exp_tflag = 1'b0;
        exp_ovr = '0;
        set_directed();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_pulses", {gain_req, pipe_tick, mix_req, out_valid}, 4'b0);
        chk("rst_out_frame", out_frame, '0);
        chk("rst_samples", {gain_sample, pipe_sample, pipe_channel}, '0);
        chk("rst_status", {timeout_flag, overrun_count, frame_count}, '0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Nominal frame with identity gain/mixer and single-cycle responders
        send_frame({16'hF000, 16'h1234});
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("nominal_latency", cyc, 15);
        chk("ready_during_out_valid", ready, 1'b0);
        @(posedge clk); #1;
        chk("ready_after_out_valid", ready, 1'b1);
        chk("out_valid_one_cycle", out_valid, 1'b0);
        wait_done();

        // Disabled pipeline stuck low must not block or time out
        pipe_enable = 2'b01;
        dead_mask = 2'b10;
        send_frame({16'h0BAD, 16'h7FFF});
        wait_done();
        chk("disabled_pipe_no_timeout", timeout_flag, 1'b0);
        pipe_enable = 2'b00;
        send_frame({16'h8000, 16'h0001});
        wait_done();
        dead_mask = '0;
        pipe_enable = '1;

        // Stuck mixer on channel 1: slot muted, flag set, frame still emitted
        plan[1] = 3;
        send_frame({16'hCAFE, 16'hBEEF});
        wait_done();
        chk("stuck_mix_flag", timeout_flag, 1'b1);
        plan[1] = 0;

        // Overrun on cycle 3 and on the EMIT cycle
        send_frame({16'h5555, 16'hAAAA});
        repeat (2) @(posedge clk);
        #1;
        pulse_fv_overrun();
        repeat (11) @(posedge clk);
        #1;
        pulse_fv_overrun();
        wait_done();
        chk("overrun_count", overrun_count, exp_ovr);

        clear_status = 1'b1;
        @(posedge clk); #1;
        clear_status = 1'b0;
        exp_ovr = '0;
        exp_tflag = 1'b0;
        chk("clear_overrun", overrun_count, exp_ovr);
        chk("clear_flag", timeout_flag, exp_tflag);

        // Clear wins over a simultaneous overrun
        send_frame({16'h1111, 16'h2222});
        repeat (1) @(posedge clk);
        #1;
        clear_status = 1'b1;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        clear_status = 1'b0;
        frame_valid = 1'b0;
        wait_done();
        chk("clear_wins", overrun_count, exp_ovr);

        // Overrun counter saturation during a long all-muted frame
        plan[0] = 3;
        plan[1] = 3;
        send_frame({16'h3333, 16'h4444});
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            pulse_fv_overrun();
        end
        wait_done();
        chk("overrun_saturate", overrun_count, exp_ovr);
        plan[0] = 0;
        plan[1] = 0;

        // Reset during channel 0 PROC_WAIT aborts the frame
        pipe_lat = 10;
        send_frame({16'h6666, 16'h7777});
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_fcnt = '0;
        exp_tflag = 1'b0;
        exp_ovr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_status", {out_valid, timeout_flag, overrun_count, frame_count}, '0);
        reset = 1'b1;
        pipe_lat = 1;
        repeat (20) @(posedge clk);
        #1;
        send_frame({16'h0F0F, 16'hF0F0});
        wait_done();

        // Randomized frames with random latencies, stalls and enables
        ident = 0;
        gain_lat = 0;
        pipe_lat = 0;
        mix_lat = 0;
        for (int f = 0; f < 24; f++) begin
            for (int c = 0; c < NCH; c++) begin
                int r;
                r = int'($urandom_range(0, 11));
                plan[c] = (r < 3) ? r + 1 : 0;
            end
            stuck_pipe = int'($urandom_range(0, NP - 1));
            pipe_enable = NP'($urandom_range(0, 3));
            send_frame(FW'($urandom));
            wait_done();
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
